seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with per-frame snapshot of in_data.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver #(
    parameter int CLK_DIV = 50000,
    parameter int DIGITS  = 8
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] in_data,
    input  logic [7:0]  dp_in,
    input  logic        en,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [2:0] D_LAST = 3'(DIGITS - 1);
    localparam logic [31:0] NMASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit_idx;
    logic [31:0]   r_shadow;
    logic [7:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_last;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [31:0]   w_shadow_m;
    logic [7:0]    w_blank;
    logic          w_dark;
    logic [7:0]    w_an_nx;
    logic [6:0]    w_seg_nx;
    logic          w_dp_nx;

    assign w_tick     = en && (r_presc == P_LAST);
    assign w_last     = (r_digit_idx == D_LAST);
    assign w_shadow_m = r_shadow & NMASK;
    assign w_nib      = w_shadow_m[{r_digit_idx, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'h7F;
        unique case (w_nib)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every higher active nibble are 0.
    always_comb begin
        w_blank = 8'h00;
        for (int i = 1; i < 8; i++) begin
            if (i < DIGITS) begin
                w_blank[i] = ((w_shadow_m >> (4 * i)) == 32'h0) && !dp_in[i];
            end
        end
    end
`else
    assign w_blank = 8'h00;
`endif

    assign w_dark = !en || w_blank[r_digit_idx];

    always_comb begin
        w_an_nx  = 8'hFF;
        w_seg_nx = 7'h7F;
        w_dp_nx  = 1'b1;
        if (!w_dark) begin
            w_an_nx  = ~(8'b1 << r_digit_idx);
            w_seg_nx = w_hex;
            w_dp_nx  = ~dp_in[r_digit_idx];
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_digit_idx  <= 3'd0;
            r_shadow     <= 32'h0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && w_last;
            if (w_tick) begin
                r_digit_idx <= w_last ? 3'd0 : r_digit_idx + 3'd1;
                if (w_last) begin
                    r_shadow <= in_data;
                end
            end
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_an_nx;
            r_seg_n <= w_seg_nx;
            r_dp_n  <= w_dp_nx;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (CLK_DIV=4, DIGITS=8).
// Build with SEG7_LZ_BLANK_EN to check the leading-zero blanking variant.
module tb_seg7_scan_driver;

    localparam int CD = 4;
    localparam int ND = 8;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        io_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic        en = 1'b0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.CLK_DIV(CD), .DIGITS(ND)) dut (
        .io_clk(io_clk),
        .resetn(resetn),
        .in_data(in_data),
        .dp_in(dp_in),
        .en(en),
        .an_n(an_n),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .frame_done(frame_done)
    );

    always #5 io_clk = ~io_clk;

    // Reference: count enabled cycles within a frame; digit and snapshot
    // points follow directly from that count.
    int          m_e = 0;
    logic [31:0] m_sh = 32'h0;

    always @(posedge io_clk) begin
        exp_t x;
        int d;
        x = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
        if (!resetn) begin
            m_e  = 0;
            m_sh = 32'h0;
        end else begin
            d = (m_e / CD) % ND;
            if (en) begin
                x.an  = ~(8'd1 << d);
                x.seg = HEX[4'((m_sh >> (4 * d)) & 32'hF)];
                x.dp  = ~dp_in[d];
`ifdef SEG7_LZ_BLANK_EN
                if (d > 0 && (m_sh >> (4 * d)) == 32'h0 && !dp_in[d]) begin
                    x.an  = 8'hFF;
                    x.seg = 7'h7F;
                    x.dp  = 1'b1;
                end
`endif
                m_e = (m_e + 1) % (CD * ND);
                if (m_e == 0) begin
                    m_sh = in_data;
                    x.fd = 1'b1;
                end
            end
        end
        sbq.push_back(x);
    end

    always @(posedge io_clk) begin
        exp_t x;
        #1;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sbq_empty t=%0t", $time);
        end else begin
            x = sbq.pop_front();
            checks++;
            if (an_n !== x.an) begin
                failures++;
                $display("FAIL an_n t=%0t got=%h exp=%h", $time, an_n, x.an);
            end
            checks++;
            if (seg_n !== x.seg) begin
                failures++;
                $display("FAIL seg_n t=%0t got=%h exp=%h", $time, seg_n, x.seg);
            end
            checks++;
            if (dp_n !== x.dp) begin
                failures++;
                $display("FAIL dp_n t=%0t got=%b exp=%b", $time, dp_n, x.dp);
            end
            checks++;
            if (frame_done !== x.fd) begin
                failures++;
                $display("FAIL frame_done t=%0t got=%b exp=%b",
                         $time, frame_done, x.fd);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    initial begin
        cyc(3);
        in_data = 32'h12345678;
        en = 1'b1;
        resetn = 1'b1;
        cyc(80);
        in_data = 32'hAAAAAAAA;
        cyc(46);
        in_data = 32'h55555555;
        cyc(80);
        dp_in = 8'h04;
        cyc(40);
        dp_in = 8'h00;
        cyc(22);
        en = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(40);
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(15) == 0) in_data = $urandom;
            if ($urandom_range(15) == 0) dp_in = 8'($urandom);
            if ($urandom_range(31) == 0) en = ~en;
            if ($urandom_range(499) == 0) begin
                resetn = 1'b0;
                cyc($urandom_range(3, 1));
                resetn = 1'b1;
            end
            cyc(1);
        end
        en = 1'b1;
        dp_in = 8'h00;
        in_data = 32'h000000A0;
        cyc(100);
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        in_data = 32'h0000000F;
        cyc(70);
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
